// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths, ALU opcodes, slot FSM states and id-width helper
package alu_arb_pkg;
    localparam int WORD_WIDTH    = 32;
    localparam int ALU_CTL_WIDTH = 4;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SEQ  = 4'd10;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SNE  = 4'd11;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SGE  = 4'd12;
    localparam logic [ALU_CTL_WIDTH-1:0] ALU_SGEU = 4'd13;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

    // Never returns 0 so a single-requester build still has a legal 1-bit tag.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational ALU; a_i/b_i operands, ctl_i opcode, y_o result (0 for unknown opcodes)
module alu
    import alu_arb_pkg::*;
#(
    parameter int W  = WORD_WIDTH,
    parameter int CW = ALU_CTL_WIDTH
) (
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    input  logic [CW-1:0] ctl_i,
    output logic [W-1:0]  y_o
);
    logic [$clog2(W)-1:0] sh;
    assign sh = b_i[$clog2(W)-1:0];
    always_comb begin
        case (ctl_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << sh;
            ALU_SLT:  y_o = W'($signed(a_i) < $signed(b_i));
            ALU_SLTU: y_o = W'(a_i < b_i);
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> sh;
            ALU_SRA:  y_o = W'($signed(a_i) >>> sh);
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_SEQ:  y_o = W'(a_i == b_i);
            ALU_SNE:  y_o = W'(a_i != b_i);
            ALU_SGE:  y_o = W'($signed(a_i) >= $signed(b_i));
            ALU_SGEU: y_o = W'(a_i >= b_i);
            default:  y_o = '0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant; req requests, ptr first index to scan, en gate, grant one-hot or zero
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant
);
    // Low copy keeps only indices >= ptr; the high copy supplies the wrap-around,
    // so the lowest set bit of the doubled vector is the round-robin winner.
    logic [2*N-1:0] dbl, iso;
    assign dbl   = {req, req & ~((N'(1) << ptr) - N'(1))};
    assign iso   = dbl & (~dbl + (2*N)'(1));
    assign grant = en ? (iso[N-1:0] | iso[2*N-1:N]) : '0;
endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one ALU among N_REQ requesters with round-robin grant and a registered result slot
//   clk, rst_n (async active-low), flush (sync clear of slot and pointer)
//   req_valid/req_ready/req_a/req_b/req_ctl: per-requester packed request handshake
//   rsp_valid/rsp_ready/rsp_data/rsp_id: result slot tagged with owning requester
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int WORD_W = WORD_WIDTH,
    parameter int CTL_W  = ALU_CTL_WIDTH,
    parameter int ID_W   = id_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*WORD_W-1:0] req_a,
    input  logic [N_REQ*WORD_W-1:0] req_b,
    input  logic [N_REQ*CTL_W-1:0]  req_ctl,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WORD_W-1:0]       rsp_data,
    output logic [ID_W-1:0]         rsp_id
);
    slot_state_t       state_q, state_d;
    logic [WORD_W-1:0] data_q, data_d, alu_y;
    logic [ID_W-1:0]   id_q, id_d, rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [N_REQ-1:0]  grant;
    logic              any_gnt;

    // flush suppresses the grant so nothing is accepted in the cycle it drops the slot.
    rr_arbiter #(.N(N_REQ), .PW(ID_W)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    ((state_q == SLOT_EMPTY || rsp_ready) && !flush),
        .grant (grant)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) if (grant[i]) gnt_idx = ID_W'(i);
    end

    alu #(.W(WORD_W), .CW(CTL_W)) u_alu (
        .a_i   (req_a[gnt_idx*WORD_W +: WORD_W]),
        .b_i   (req_b[gnt_idx*WORD_W +: WORD_W]),
        .ctl_i (req_ctl[gnt_idx*CTL_W +: CTL_W]),
        .y_o   (alu_y)
    );

    assign any_gnt = |grant;

    always_comb begin
        state_d  = flush ? SLOT_EMPTY : any_gnt ? SLOT_FULL : rsp_ready ? SLOT_EMPTY : state_q;
        data_d   = any_gnt ? alu_y : data_q;
        id_d     = any_gnt ? gnt_idx : id_q;
        rr_ptr_d = flush ? '0 : !any_gnt ? rr_ptr_q :
                   (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SLOT_EMPTY;
            data_q   <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = (state_q == SLOT_FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed self-checking bench for alu_rr_arbiter
module tb_alu_rr_arbiter;
    import alu_arb_pkg::*;

    logic        clk = 0, rst_n = 0, flush = 0, rsp_ready = 1;
    logic [1:0]  req_valid = '0, req_ready;
    logic [63:0] req_a = '0, req_b = '0;
    logic [7:0]  req_ctl = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_id;
    int          total = 0, passed = 0;

    alu_rr_arbiter #(.N_REQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ctl   (req_ctl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic setreq(input int i, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_ctl[i*4 +: 4] = ctl;
    endtask

    // Checks combinational ready in the current cycle, then the slot after the edge.
    task automatic cyc(input string tag, input logic [1:0] rdy, input logic v, input logic [31:0] d, input logic id);
        #1 chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, ".data"}, rsp_data, d);
        chk({tag, ".id"}, 32'(rsp_id), 32'(id));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(rsp_valid), 0);
        chk("rst.data", rsp_data, 0);
        chk("rst.id", 32'(rsp_id), 0);
        chk("rst.ready", 32'(req_ready), 0);
        @(negedge clk) rst_n = 1;

        setreq(0, ALU_ADD, 5, 7);
        req_valid = 2'b01;
        cyc("t1", 2'b01, 1, 12, 0);

        req_valid = 2'b00;
        flush = 1;
        cyc("flush0", 2'b00, 0, 12, 0);
        chk("flush0.ptr", 32'(dut.rr_ptr_q), 0);
        flush = 0;

        setreq(0, ALU_SUB, 10, 3);
        setreq(1, ALU_SLT, 32'hFFFF_FFFF, 1);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++)
            cyc("t2", (i % 2 == 0) ? 2'b01 : 2'b10, 1, (i % 2 == 0) ? 32'd7 : 32'd1, 1'(i % 2));

        setreq(0, ALU_ADD, 5, 7);
        setreq(1, ALU_ADD, 1, 2);
        req_valid = 2'b01;
        cyc("t3.fill", 2'b01, 1, 12, 0);
        req_valid = 2'b10;
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) cyc("t3.hold", 2'b00, 1, 12, 0);
        rsp_ready = 1;
        cyc("t3.release", 2'b10, 1, 3, 1);

        req_valid = 2'b01;
        cyc("t4.fill", 2'b01, 1, 12, 0);
        chk("t4.ptr1", 32'(dut.rr_ptr_q), 1);
        flush = 1;
        req_valid = 2'b11;
        cyc("t4.flush", 2'b00, 0, 12, 0);
        chk("t4.ptr0", 32'(dut.rr_ptr_q), 0);
        flush = 0;
        cyc("t4.after", 2'b01, 1, 12, 0);

        req_valid = 2'b00;
        rsp_ready = 0;
        #2 chk("t5.pre", 32'(rsp_valid), 1);
        rst_n = 0;
        #1;
        chk("t5.valid", 32'(rsp_valid), 0);
        chk("t5.data", rsp_data, 0);
        chk("t5.id", 32'(rsp_id), 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        rsp_ready = 1;

        setreq(1, ALU_SRA, 32'h8000_0000, 4);
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            cyc("t6", 2'b10, 1, 32'hF800_0000, 1);
            chk("t6.ptr", 32'(dut.rr_ptr_q), 0);
        end

        setreq(0, 4'd15, 5, 7);
        req_valid = 2'b01;
        cyc("badctl", 2'b01, 1, 0, 0);
        setreq(0, ALU_ADD, 32'hFFFF_FFFF, 2);
        cyc("wrap", 2'b01, 1, 1, 0);
        req_valid = 2'b00;
        cyc("drain", 2'b00, 0, 1, 0);
        chk("drain.ptr", 32'(dut.rr_ptr_q), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
